// File: rtl/cpu_pipelined.sv
// Five-stage in-order RV32I-subset core (add/sub/and/or/addi/lw/sw/beq)
// with EX forwarding, load-use stall, predict-not-taken branches resolved
// in EX, and a halt word that freezes fetch and raises end_program.

// Instruction memory: combinational read, word-indexed; write port tied off
module imem (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:63];
    assign rdata = memory[raddr];
    // Optional load port, held idle by the core; contents survive reset
    always_ff @(posedge clk) if (we) memory[waddr] <= wdata;
endmodule

// Data memory: combinational read, synchronous write
module dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:63];
    assign rdata = memory[addr];
    // Store commits at the end of MEM
    always_ff @(posedge clk) if (we) memory[addr] <= wdata;
endmodule

// Register file: two read ports with write-through bypass, x0 hardwired
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : registers[ra2];
    // Writeback port; writes to x0 are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end
endmodule

module cpu_pipelined (
    input  logic clk,
    input  logic reset,
    output logic end_program
);
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [1:0]  OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3;

    logic [31:0] pc_q, pc_d;
    logic        end_q, end_d;
    logic [31:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
    logic [31:0] idex_pc_q, idex_pc_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;
    logic [4:0]  idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d, idex_rd_q, idex_rd_d;
    logic        idex_rw_q, idex_rw_d, idex_mr_q, idex_mr_d, idex_mw_q, idex_mw_d;
    logic        idex_br_q, idex_br_d, idex_src_q, idex_src_d;
    logic [1:0]  idex_op_q, idex_op_d;
    logic        exmem_rw_q, exmem_rw_d, exmem_mr_q, exmem_mr_d, exmem_mw_q, exmem_mw_d;
    logic [4:0]  exmem_rd_q, exmem_rd_d;
    logic [31:0] exmem_alu_q, exmem_alu_d, exmem_sd_q, exmem_sd_d;
    logic        memwb_rw_q, memwb_rw_d;
    logic [4:0]  memwb_rd_q, memwb_rd_d;
    logic [31:0] memwb_res_q, memwb_res_d;

    logic [31:0] fetch, rf_a, rf_b, dm_rdata;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
    logic        br_taken, load_use;

    imem imem (.clk(clk), .we(1'b0), .waddr(6'd0), .wdata(32'd0), .raddr(pc_q[7:2]), .rdata(fetch));

    reg_file reg_file (.clk(clk), .reset(reset),
                       .ra1(ifid_instr_q[19:15]), .ra2(ifid_instr_q[24:20]), .rd1(rf_a), .rd2(rf_b),
                       .we(memwb_rw_q), .wa(memwb_rd_q), .wd(memwb_res_q));

    dmem dmem (.clk(clk), .we(exmem_mw_q), .addr(exmem_alu_q[7:2]), .wdata(exmem_sd_q), .rdata(dm_rdata));

    assign end_program = end_q;

    // Next-state logic for every pipeline stage, hazards and halt
    always_comb begin
        logic [31:0] ins;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        ins = ifid_instr_q;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];

        // EX: forwarding, ALU and branch resolution
        fwd_a = idex_a_q;
        if (exmem_rw_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q)      fwd_a = exmem_alu_q;
        else if (memwb_rw_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q) fwd_a = memwb_res_q;
        fwd_b = idex_b_q;
        if (exmem_rw_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q)      fwd_b = exmem_alu_q;
        else if (memwb_rw_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q) fwd_b = memwb_res_q;
        alu_b = idex_src_q ? idex_imm_q : fwd_b;
        case (idex_op_q)
            OP_SUB:  alu_y = fwd_a - alu_b;
            OP_AND:  alu_y = fwd_a & alu_b;
            OP_OR:   alu_y = fwd_a | alu_b;
            default: alu_y = fwd_a + alu_b;
        endcase
        br_taken = idex_br_q && (fwd_a == fwd_b);
        load_use = idex_mr_q && idex_rd_q != 5'd0 &&
                   (idex_rd_q == ins[19:15] || idex_rd_q == ins[24:20]);

        exmem_rw_d  = idex_rw_q;
        exmem_mr_d  = idex_mr_q;
        exmem_mw_d  = idex_mw_q;
        exmem_rd_d  = idex_rd_q;
        exmem_alu_d = alu_y;
        exmem_sd_d  = fwd_b;

        // MEM -> WB
        memwb_rw_d  = exmem_rw_q;
        memwb_rd_d  = exmem_rd_q;
        memwb_res_d = exmem_mr_q ? dm_rdata : exmem_alu_q;

        // ID: decode into ID/EX; unknown encodings leave all controls low
        idex_pc_d  = ifid_pc_q;
        idex_a_d   = rf_a;
        idex_b_d   = rf_b;
        idex_rs1_d = ins[19:15];
        idex_rs2_d = ins[24:20];
        idex_rd_d  = 5'd0;
        idex_imm_d = {{20{ins[31]}}, ins[31:20]};
        idex_rw_d  = 1'b0;
        idex_mr_d  = 1'b0;
        idex_mw_d  = 1'b0;
        idex_br_d  = 1'b0;
        idex_src_d = 1'b0;
        idex_op_d  = OP_ADD;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111)) begin
                    idex_rw_d = 1'b1;
                    idex_rd_d = ins[11:7];
                    idex_op_d = (f3 == 3'b111) ? OP_AND : (f3 == 3'b110) ? OP_OR : OP_ADD;
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    idex_rw_d = 1'b1;
                    idex_rd_d = ins[11:7];
                    idex_op_d = OP_SUB;
                end
            end
            7'b0010011: if (f3 == 3'b000) begin
                idex_rw_d  = 1'b1;
                idex_rd_d  = ins[11:7];
                idex_src_d = 1'b1;
            end
            7'b0000011: if (f3 == 3'b010) begin
                idex_rw_d  = 1'b1;
                idex_mr_d  = 1'b1;
                idex_rd_d  = ins[11:7];
                idex_src_d = 1'b1;
            end
            7'b0100011: if (f3 == 3'b010) begin
                idex_mw_d  = 1'b1;
                idex_src_d = 1'b1;
                idex_imm_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: if (f3 == 3'b000) begin
                idex_br_d  = 1'b1;
                idex_imm_d = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: ;
        endcase

        // IF and control priority: taken branch > load-use stall > halt > advance
        pc_d         = pc_q;
        end_d        = end_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (br_taken || load_use) begin
            idex_rw_d = 1'b0;
            idex_mr_d = 1'b0;
            idex_mw_d = 1'b0;
            idex_br_d = 1'b0;
        end
        if (br_taken) begin
            pc_d         = idex_pc_q + idex_imm_q;
            end_d        = 1'b0;
            ifid_instr_d = 32'd0;
        end else if (load_use) begin
            // hold PC and IF/ID for one cycle
        end else if (fetch == HALT) begin
            ifid_instr_d = 32'd0;
            end_d        = 1'b1;
        end else begin
            pc_d         = pc_q + 32'd4;
            ifid_pc_d    = pc_q;
            ifid_instr_d = fetch;
        end
    end

    // Pipeline registers; reset turns every stage into a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0; end_q <= 1'b0; ifid_pc_q <= '0; ifid_instr_q <= '0;
            idex_pc_q <= '0; idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0;
            idex_rs1_q <= '0; idex_rs2_q <= '0; idex_rd_q <= '0; idex_op_q <= '0;
            idex_rw_q <= 1'b0; idex_mr_q <= 1'b0; idex_mw_q <= 1'b0; idex_br_q <= 1'b0; idex_src_q <= 1'b0;
            exmem_rw_q <= 1'b0; exmem_mr_q <= 1'b0; exmem_mw_q <= 1'b0;
            exmem_rd_q <= '0; exmem_alu_q <= '0; exmem_sd_q <= '0;
            memwb_rw_q <= 1'b0; memwb_rd_q <= '0; memwb_res_q <= '0;
        end else begin
            pc_q <= pc_d; end_q <= end_d; ifid_pc_q <= ifid_pc_d; ifid_instr_q <= ifid_instr_d;
            idex_pc_q <= idex_pc_d; idex_a_q <= idex_a_d; idex_b_q <= idex_b_d; idex_imm_q <= idex_imm_d;
            idex_rs1_q <= idex_rs1_d; idex_rs2_q <= idex_rs2_d; idex_rd_q <= idex_rd_d; idex_op_q <= idex_op_d;
            idex_rw_q <= idex_rw_d; idex_mr_q <= idex_mr_d; idex_mw_q <= idex_mw_d; idex_br_q <= idex_br_d;
            idex_src_q <= idex_src_d;
            exmem_rw_q <= exmem_rw_d; exmem_mr_q <= exmem_mr_d; exmem_mw_q <= exmem_mw_d;
            exmem_rd_q <= exmem_rd_d; exmem_alu_q <= exmem_alu_d; exmem_sd_q <= exmem_sd_d;
            memwb_rw_q <= memwb_rw_d; memwb_rd_q <= memwb_rd_d; memwb_res_q <= memwb_res_d;
        end
    end
endmodule

// File: tb/tb_cpu_pipelined.sv
// Directed program tests for cpu_pipelined: hazards, forwarding, stores,
// branch flush, x0 handling and mid-run reset.
module tb_cpu_pipelined;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic end_program;
    int   checks = 0;
    int   errors = 0;

    cpu_pipelined dut (.clk(clk), .reset(reset), .end_program(end_program));

    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hold reset, fill imem with halts and dmem with zeros
    task automatic clear_mems();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dut.imem.memory[i] = 32'hFFFF_FFFF;
            dut.dmem.memory[i] = 32'd0;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for end_program (bounded) then let the pipeline drain
    task automatic run_to_end(input string tag);
        int n;
        n = 0;
        while (end_program !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_end"}, {31'd0, end_program}, 32'd1);
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [31:0] rg(input int i);
        return dut.reg_file.registers[i];
    endfunction

    initial begin
        int nz;

        // Reset state
        clear_mems();
        @(negedge clk);
        chk("rst_end", {31'd0, end_program}, 32'd0);
        chk("rst_pc", dut.pc_q, 32'd0);

        // Hazard program
        dut.dmem.memory[0] = 32'd5;
        dut.imem.memory[0] = lw(5'd2, 5'd0, 12'd0);
        dut.imem.memory[1] = addi(5'd4, 5'd2, 12'd1);
        dut.imem.memory[2] = r_op(7'd0, 5'd2, 5'd6, 3'b000, 5'd8);
        dut.imem.memory[3] = r_op(7'd0, 5'd2, 5'd4, 3'b000, 5'd9);
        release_reset();
        run_to_end("haz");
        chk("haz_x2", rg(2), 32'd5);
        chk("haz_x4", rg(4), 32'd6);
        chk("haz_x8", rg(8), 32'd5);
        chk("haz_x9", rg(9), 32'd11);
        nz = 0;
        for (int i = 0; i < 32; i++)
            if (i != 2 && i != 4 && i != 8 && i != 9 && rg(i) != 32'd0) nz++;
        chk("haz_others", nz, 32'd0);
        chk("haz_dmem0", dut.dmem.memory[0], 32'd5);
        chk("haz_end_hold", {31'd0, end_program}, 32'd1);

        // Forwarding chain
        clear_mems();
        dut.imem.memory[0] = addi(5'd1, 5'd0, 12'd7);
        dut.imem.memory[1] = r_op(7'd0, 5'd1, 5'd1, 3'b000, 5'd2);
        dut.imem.memory[2] = r_op(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);
        dut.imem.memory[3] = r_op(7'd0, 5'd2, 5'd3, 3'b111, 5'd4);
        dut.imem.memory[4] = r_op(7'd0, 5'd1, 5'd4, 3'b110, 5'd5);
        release_reset();
        run_to_end("fwd");
        chk("fwd_x1", rg(1), 32'd7);
        chk("fwd_x2", rg(2), 32'd14);
        chk("fwd_x3", rg(3), 32'd7);
        chk("fwd_x4", rg(4), 32'd6);
        chk("fwd_x5", rg(5), 32'd7);

        // Store forwarding
        clear_mems();
        dut.imem.memory[0] = addi(5'd1, 5'd0, 12'd9);
        dut.imem.memory[1] = sw(5'd1, 5'd0, 12'd8);
        dut.imem.memory[2] = lw(5'd2, 5'd0, 12'd8);
        dut.imem.memory[3] = addi(5'd3, 5'd2, 12'd1);
        release_reset();
        run_to_end("st");
        chk("st_dmem2", dut.dmem.memory[2], 32'd9);
        chk("st_x2", rg(2), 32'd9);
        chk("st_x3", rg(3), 32'd10);

        // Branch flush
        clear_mems();
        dut.imem.memory[0] = addi(5'd1, 5'd0, 12'd1);
        dut.imem.memory[1] = beq(5'd1, 5'd1, 13'd12);
        dut.imem.memory[2] = addi(5'd2, 5'd0, 12'd5);
        dut.imem.memory[3] = addi(5'd3, 5'd0, 12'd6);
        dut.imem.memory[4] = addi(5'd4, 5'd0, 12'd3);
        release_reset();
        run_to_end("br");
        chk("br_x1", rg(1), 32'd1);
        chk("br_x2", rg(2), 32'd0);
        chk("br_x3", rg(3), 32'd0);
        chk("br_x4", rg(4), 32'd3);

        // x0 handling and reset
        clear_mems();
        dut.imem.memory[0] = addi(5'd0, 5'd0, 12'd5);
        dut.imem.memory[1] = r_op(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
        dut.imem.memory[2] = addi(5'd2, 5'd0, 12'd3);
        release_reset();
        repeat (6) @(negedge clk);
        chk("x0_mid", rg(0), 32'd0);
        run_to_end("x0");
        chk("x0_x0", rg(0), 32'd0);
        chk("x0_x1", rg(1), 32'd0);
        chk("x0_x2", rg(2), 32'd3);

        // Asynchronous reset between edges clears state immediately
        #2 reset = 1'b1;
        #1;
        chk("ar_pc", dut.pc_q, 32'd0);
        chk("ar_end", {31'd0, end_program}, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (rg(i) != 32'd0) nz++;
        chk("ar_regs", nz, 32'd0);
        chk("ar_imem2", dut.imem.memory[2], addi(5'd2, 5'd0, 12'd3));

        // Re-run, reset again mid-program, then let it finish
        release_reset();
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mr_pc", dut.pc_q, 32'd0);
        chk("mr_end", {31'd0, end_program}, 32'd0);
        release_reset();
        run_to_end("rr");
        chk("rr_x0", rg(0), 32'd0);
        chk("rr_x1", rg(1), 32'd0);
        chk("rr_x2", rg(2), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
